// File: rtl/ctrl_sequencer.sv
// Multicycle control sequencer: fetch (PC->MAR->MDR->IR), then ALU3 or MUL/DIV execute.
// Optional macro R0_WRITE_GUARD_EN: ALU3 results targeting R0 are discarded.
module ctrl_sequencer #(
  parameter int unsigned ALU_WAIT  = 0,
  parameter int unsigned REG_COUNT = 16
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 run,
  input  logic                 mem_ready,
  input  logic [31:0]          ir,
  output logic [REG_COUNT-1:0] Rin,
  output logic [REG_COUNT-1:0] Rout,
  output logic                 PCout,
  output logic                 incPC,
  output logic                 MARin,
  output logic                 read,
  output logic                 MDRin,
  output logic                 MDRout,
  output logic                 IRin,
  output logic                 Yin,
  output logic                 Zin,
  output logic                 ZLowOut,
  output logic                 ZHighOut,
  output logic                 LOin,
  output logic                 HIin,
  output logic [4:0]           opcode,
  output logic                 done,
  output logic                 fault,
  output logic [3:0]           state
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_FAULT = 4'd8
  } state_t;

  state_t     cur_state;
  state_t     nxt_state;
  logic [3:0] wait_cnt;

  logic [4:0] op;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic       is_alu3;
  logic       is_muldiv;
  logic       wait_last;
  logic       unused_ir;

  assign op        = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign unused_ir = ^ir[14:0];
  assign is_alu3   = (op >= 5'd3) && (op <= 5'd13);
  assign is_muldiv = (op == 5'd14) || (op == 5'd15);
  assign wait_last = ({28'd0, wait_cnt} == ALU_WAIT);
  assign state     = cur_state;

  // Register indices beyond REG_COUNT decode to no select at all.
  function automatic logic [REG_COUNT-1:0] reg_sel(input logic [3:0] idx);
    logic [REG_COUNT-1:0] sel;
    sel = '0;
    for (int unsigned i = 0; i < REG_COUNT; i++) begin
      if ({28'd0, idx} == i) sel[i] = 1'b1;
    end
    return sel;
  endfunction

  always_ff @(posedge clock) begin
    if (clear) begin
      cur_state <= S_IDLE;
      wait_cnt  <= '0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == S_T4 && !wait_last) wait_cnt <= wait_cnt + 4'd1;
      else                                 wait_cnt <= '0;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    Rin       = '0;
    Rout      = '0;
    PCout     = 1'b0;
    incPC     = 1'b0;
    MARin     = 1'b0;
    read      = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zin       = 1'b0;
    ZLowOut   = 1'b0;
    ZHighOut  = 1'b0;
    LOin      = 1'b0;
    HIin      = 1'b0;
    opcode    = '0;
    done      = 1'b0;
    fault     = 1'b0;

    case (cur_state)
      S_IDLE: if (run) nxt_state = S_T0;
      S_T0: begin
        PCout     = 1'b1;
        MARin     = 1'b1;
        incPC     = 1'b1;
        nxt_state = S_T1;
      end
      S_T1: begin
        read  = 1'b1;
        MDRin = 1'b1;
        if (mem_ready) nxt_state = S_T2;
      end
      S_T2: begin
        MDRout    = 1'b1;
        IRin      = 1'b1;
        nxt_state = S_T3;
      end
      S_T3: begin
        if (is_alu3 || is_muldiv) begin
          Rout      = reg_sel(rb);
          Yin       = 1'b1;
          nxt_state = S_T4;
        end else begin
          nxt_state = S_FAULT;
        end
      end
      S_T4: begin
        Rout   = reg_sel(rc);
        opcode = op;
        if (wait_last) begin
          Zin       = 1'b1;
          nxt_state = S_T5;
        end
      end
      S_T5: begin
        ZLowOut = 1'b1;
        if (is_muldiv) begin
          LOin      = 1'b1;
          nxt_state = S_T6;
        end else begin
`ifdef R0_WRITE_GUARD_EN
          if (ra != 4'd0) Rin = reg_sel(ra);
`else
          Rin = reg_sel(ra);
`endif
          done      = 1'b1;
          nxt_state = run ? S_T0 : S_IDLE;
        end
      end
      S_T6: begin
        ZHighOut  = 1'b1;
        HIin      = 1'b1;
        done      = 1'b1;
        nxt_state = run ? S_T0 : S_IDLE;
      end
      S_FAULT: fault = 1'b1;
      default: nxt_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: stimulus pushes per-cycle expected outputs, a monitor compares.
module tb_ctrl_sequencer;
  localparam int unsigned RC = 12;
  localparam int unsigned AW = 2;

  logic          clock = 1'b0;
  logic          clear, run, mem_ready;
  logic [31:0]   ir;
  logic [RC-1:0] Rin, Rout;
  logic          PCout, incPC, MARin, read, MDRin, MDRout, IRin, Yin, Zin;
  logic          ZLowOut, ZHighOut, LOin, HIin, done, fault;
  logic [4:0]    opcode;
  logic [3:0]    state;

  typedef struct packed {
    logic [3:0]    st;
    logic [RC-1:0] rin;
    logic [RC-1:0] rout;
    logic pcout, incpc, marin, rd, mdrin, mdrout, irin, yin, zin, zlo, zhi, loin, hiin;
    logic [4:0]    opc;
    logic          dn;
    logic          flt;
  } exp_t;

  exp_t        exp_q[$];
  string       tag_q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  bit          in_idle;
  exp_t        mon_exp, mon_act;
  string       mon_tag;

  always #5 clock = ~clock;

  ctrl_sequencer #(.ALU_WAIT(AW), .REG_COUNT(RC)) dut (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
    .Rin(Rin), .Rout(Rout), .PCout(PCout), .incPC(incPC), .MARin(MARin),
    .read(read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .Zin(Zin), .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .LOin(LOin), .HIin(HIin),
    .opcode(opcode), .done(done), .fault(fault), .state(state)
  );

  function automatic logic [RC-1:0] reg_bit(input int unsigned idx);
    logic [RC-1:0] v;
    v = '0;
    if (idx < RC) v[idx] = 1'b1;
    return v;
  endfunction

  function automatic exp_t quiet(input int unsigned st);
    exp_t e;
    e    = '0;
    e.st = 4'(st);
    return e;
  endfunction

  function automatic logic coin();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic step(input exp_t e, input string tag, input logic r, input logic mr, input logic clr);
    run       = r;
    mem_ready = mr;
    clear     = clr;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
  endtask

  // One whole instruction: expected cycle-by-cycle output trace derived from the opcode class.
  task automatic do_instr(input logic [31:0] word, input int unsigned stall,
                          input bit run_after, input bit abort_t4, input string name);
    exp_t        e;
    int unsigned op, ra, rb, rc, nf;
    bit          alu3, md, guard;
    op    = word[31:27];
    ra    = word[26:23];
    rb    = word[22:19];
    rc    = word[18:15];
    alu3  = (op >= 3) && (op <= 13);
    md    = (op == 14) || (op == 15);
    guard = 1'b0;
`ifdef R0_WRITE_GUARD_EN
    guard = (ra == 0);
`endif
    if (in_idle) begin
      repeat ($urandom_range(0, 2)) step(quiet(0), {name, "/idle"}, 1'b0, coin(), 1'b0);
      step(quiet(0), {name, "/idle_go"}, 1'b1, coin(), 1'b0);
    end
    ir = word;
    e = quiet(1); e.pcout = 1; e.marin = 1; e.incpc = 1;
    step(e, {name, "/T0"}, coin(), coin(), 1'b0);
    for (int unsigned i = 0; i <= stall; i++) begin
      e = quiet(2); e.rd = 1; e.mdrin = 1;
      step(e, {name, "/T1"}, coin(), (i == stall), 1'b0);
    end
    e = quiet(3); e.mdrout = 1; e.irin = 1;
    step(e, {name, "/T2"}, coin(), coin(), 1'b0);
    if (!alu3 && !md) begin
      step(quiet(4), {name, "/T3_illegal"}, coin(), coin(), 1'b0);
      nf = $urandom_range(1, 3);
      for (int unsigned i = 0; i < nf; i++) begin
        e = quiet(8); e.flt = 1;
        step(e, {name, "/FAULT"}, coin(), coin(), (i == nf - 1));
      end
      in_idle = 1;
      return;
    end
    e = quiet(4); e.rout = reg_bit(rb); e.yin = 1;
    step(e, {name, "/T3"}, coin(), coin(), 1'b0);
    for (int unsigned i = 0; i <= AW; i++) begin
      e = quiet(5); e.rout = reg_bit(rc); e.opc = 5'(op); e.zin = (i == AW);
      step(e, {name, "/T4"}, coin(), coin(), abort_t4 && (i == 1));
      if (abort_t4 && (i == 1)) begin
        in_idle = 1;
        return;
      end
    end
    e = quiet(6); e.zlo = 1;
    if (md) begin
      e.loin = 1;
      step(e, {name, "/T5"}, coin(), coin(), 1'b0);
      e = quiet(7); e.zhi = 1; e.hiin = 1; e.dn = 1;
      step(e, {name, "/T6"}, run_after, coin(), 1'b0);
    end else begin
      e.rin = guard ? '0 : reg_bit(ra);
      e.dn  = 1;
      step(e, {name, "/T5"}, run_after, coin(), 1'b0);
    end
    in_idle = !run_after;
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_exp        = exp_q.pop_front();
      mon_tag        = tag_q.pop_front();
      mon_act.st     = state;
      mon_act.rin    = Rin;
      mon_act.rout   = Rout;
      mon_act.pcout  = PCout;
      mon_act.incpc  = incPC;
      mon_act.marin  = MARin;
      mon_act.rd     = read;
      mon_act.mdrin  = MDRin;
      mon_act.mdrout = MDRout;
      mon_act.irin   = IRin;
      mon_act.yin    = Yin;
      mon_act.zin    = Zin;
      mon_act.zlo    = ZLowOut;
      mon_act.zhi    = ZHighOut;
      mon_act.loin   = LOin;
      mon_act.hiin   = HIin;
      mon_act.opc    = opcode;
      mon_act.dn     = done;
      mon_act.flt    = fault;
      n_checks++;
      if (mon_act !== mon_exp) begin
        n_errors++;
        $display("FAIL %s: got state=%0d Rin=%h Rout=%h vec=%h, expected state=%0d Rin=%h Rout=%h vec=%h",
                 mon_tag, mon_act.st, mon_act.rin, mon_act.rout, mon_act,
                 mon_exp.st, mon_exp.rin, mon_exp.rout, mon_exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: stimulus did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    clear     = 1'b1;
    run       = 1'b0;
    mem_ready = 1'b0;
    ir        = '0;
    in_idle   = 1;
    @(posedge clock);
    #1;
    step(quiet(0), "reset", 1'b0, 1'b0, 1'b1);

    do_instr(32'h1A1B8000, 0, 1'b1, 1'b0, "add_r4_r3_r7");
    do_instr(32'h78130000, 4, 1'b0, 1'b0, "div_stall4");
    do_instr(32'h78130000, 0, 1'b1, 1'b1, "div_reset_in_t4");
    do_instr({5'h1F, 27'h0}, 1, 1'b0, 1'b0, "illegal_op31");
    do_instr({5'd3, 4'd0, 4'd1, 4'd2, 15'h0}, 0, 1'b1, 1'b0, "add_ra0");
    do_instr({5'd4, 4'd14, 4'd13, 4'd15, 15'h0}, 0, 1'b0, 1'b0, "reg_out_of_range");
    do_instr({5'd14, 4'd11, 4'd0, 4'd11, 15'h0}, 2, 1'b1, 1'b0, "mul_edge_regs");

    for (int unsigned n = 0; n < 80; n++) begin
      w = $urandom();
      if ($urandom_range(0, 9) < 8) w[31:27] = 5'($urandom_range(3, 15));
      do_instr(w, $urandom_range(0, 5), coin(), ($urandom_range(0, 15) == 0), "rand");
    end

    @(negedge clock);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Multicycle control unit that drives the datapath's load/drive/select strobes, replacing hand-sequenced bench stimulus.
- Fetches an instruction via PC→MAR→MDR→IR, then executes 3-operand ALU ops (result to Ra) and MUL/DIV (result to HI/LO).
- Sits beside the datapath. Its outputs connect one-to-one to the datapath control inputs. It reads back the IR contents.

Parameters:
- ALU_WAIT, 0: extra cycles T4 holds operands before Zin is pulsed (0–15). Covers slow MUL/DIV.
- REG_COUNT, 16: number of general registers; width of the one-hot Rin/Rout buses.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  synchronous active-high reset.
- run  in  1  level. While high, instructions are fetched back-to-back.
- mem_ready  in  1  memory data valid; qualifies the T1 read.
- ir  in  32  datapath IR contents. Fields: op=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15].
- Rin  out  REG_COUNT  one-hot register load.
- Rout  out  REG_COUNT  one-hot register drive.
- PCout, incPC, MARin, read, MDRin, MDRout, IRin, Yin, Zin, ZLowOut, ZHighOut, LOin, HIin  out  1 each  datapath strobes.
- opcode  out  5  ALU function select.
- done  out  1  one-cycle pulse at instruction completion.
- fault  out  1  sticky illegal-opcode flag.
- state  out  4  current state code, for debug.

Behaviour:
- State codes: IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7, FAULT=8.
- Outputs are a combinational decode of the state register plus ir. Every strobe not listed for a state is 0.
- On clear (sampled at a rising edge, valid in any state including mid-instruction):
  - state←IDLE; wait counter←0; fault←0.
  - All outputs 0, opcode=0.
- IDLE: all outputs 0. Goes to T0 when run=1.
- T0: PCout, MARin, incPC. Next state T1.
- T1: read, MDRin, held while mem_ready=0. Goes to T2 on the cycle mem_ready=1; MDR loads on that edge.
- T2: MDRout, IRin. Next state T3. ir is valid from T3 onward.
- T3 decode:
  - op 00011–01101 = ALU3 class.
  - op 01110 (MUL) and 01111 (DIV) = MULDIV class.
  - Any other op: go to FAULT with no strobes asserted in T3.
  - Legal op: Rout[Rb], Yin. Next state T4.
- T4: Rout[Rc], opcode=op.
  - Stays ALU_WAIT+1 cycles, counted by the wait counter.
  - Zin is asserted only on the final cycle. Then go to T5.
- T5:
  - ALU3: ZLowOut, Rin[Ra], done. Then go to T0 if run=1, else IDLE.
  - MULDIV: ZLowOut, LOin. Then go to T6.
- T6 (MULDIV only): ZHighOut, HIin, done. Then go to T0 if run=1, else IDLE.
- FAULT: fault=1, all strobes 0. Held until clear.
- run is sampled only in IDLE and on the completing cycle. Dropping run mid-instruction does not abort it.
- Register index ≥ REG_COUNT: the corresponding Rin/Rout is all zeros.
- At most one Rout bit and at most one bus driver (PCout/MDRout/ZLowOut/ZHighOut/Rout) are active per cycle.

Optional Feature:
- Macro: R0_WRITE_GUARD_EN.
- When defined: an ALU3 with Ra=0 suppresses Rin[0] in T5; done still pulses; R0 is never written.
- When undefined: Rin[0] is asserted normally.

Test Plan:
- Reset mid-T4 (ir=0x78130000, ALU_WAIT=3) → next cycle state=0, all outputs 0, fault=0.
- run=1, mem_ready=1, ir=0x1A1B8000 (ADD R4,R3,R7) → states 1,2,3,4,5,6.
  - T3: Rout=0x0008, Yin.
  - T4: Rout=0x0080, opcode=00011, Zin.
  - T5: Rin=0x0010, ZLowOut, done.
- ir=0x78130000 (DIV R2,R6), ALU_WAIT=2:
  - T3: Rout=0x0004.
  - T4 lasts 3 cycles with Rout=0x0040 and opcode=01111; Zin only on the 3rd.
  - T5: LOin; T6: HIin, done.
- mem_ready low for 4 cycles in T1 → read/MDRin held 5 cycles; IRin is not asserted early.
- ir op=11111 → state=8, fault=1, no Yin. Holds until clear.
- R0_WRITE_GUARD_EN defined, ADD with Ra=0 → Rin=0 in T5, done=1.
